// File: rtl/mul_share_sched.sv
// Round-robin sequencer sharing one 16x16 multiplier among N_REQ requesters.
// Define MUL_SHARE_FIXED_PRIO_EN to replace round-robin with fixed (lowest-index) priority.
module mul_share_sched #(
  parameter int N_REQ   = 4,
  parameter int MUL_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [16*N_REQ-1:0]  req_a,
  input  logic [16*N_REQ-1:0]  req_b,
  output logic [N_REQ-1:0]     rsp_valid,
  input  logic [N_REQ-1:0]     rsp_ready,
  output logic [31:0]          rsp_data,
  output logic [15:0]          mul_a,
  output logic [15:0]          mul_b,
  input  logic [31:0]          mul_p,
  output logic                 busy
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic [IDX_W-1:0]   idx_r;
  logic [IDX_W-1:0]   grant_s;
  logic               grant_found_s;
  logic [3:0]         cnt_r;
  logic               req_hs_s;
  logic               rsp_hs_s;
  logic               cnt_zero_s;

  function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
    logic [N_REQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

`ifdef MUL_SHARE_FIXED_PRIO_EN
  // Fixed priority: descending scan so the lowest valid index is assigned last
  always_comb begin
    grant_found_s = 1'b0;
    grant_s       = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      grant_s       = req_valid[i] ? IDX_W'(i) : grant_s;
      grant_found_s = grant_found_s | req_valid[i];
    end
  end
`else
  logic [IDX_W-1:0] last_r;
  logic [IDX_W-1:0] cand_s;

  // Round-robin: scan from last+N_REQ down to last+1 so the nearest successor wins
  always_comb begin
    grant_found_s = 1'b0;
    grant_s       = '0;
    cand_s        = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand_s        = IDX_W'((int'(last_r) + k) % N_REQ);
      grant_s       = req_valid[cand_s] ? cand_s : grant_s;
      grant_found_s = grant_found_s | req_valid[cand_s];
    end
  end

  // Round-robin pointer, moves only on an accepted request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_r <= IDX_W'(N_REQ - 1);
    end else if (req_hs_s) begin
      last_r <= grant_s;
    end else begin
      last_r <= last_r;
    end
  end
`endif

  assign req_hs_s   = (state_r == IDLE) && grant_found_s;
  assign rsp_hs_s   = (state_r == RESP) && rsp_ready[idx_r];
  assign cnt_zero_s = (cnt_r == 4'd0);

  // Accept strobe for the winner only, and only while idle
  always_comb begin
    req_ready = '0;
    if (req_hs_s) begin
      req_ready = onehot(grant_s);
    end else begin
      req_ready = '0;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    state_s = req_hs_s   ? MUL  : IDLE;
      MUL:     state_s = cnt_zero_s ? RESP : MUL;
      RESP:    state_s = rsp_hs_s   ? IDLE : RESP;
      default: state_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand latch, settle counter, product capture and response flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_a     <= 16'h0000;
      mul_b     <= 16'h0000;
      idx_r     <= '0;
      cnt_r     <= 4'd0;
      rsp_data  <= 32'h0000_0000;
      rsp_valid <= '0;
      busy      <= 1'b0;
    end else begin
      busy <= (state_s != IDLE);
      if (req_hs_s) begin
        mul_a <= req_a[{grant_s, 4'h0} +: 16];
        mul_b <= req_b[{grant_s, 4'h0} +: 16];
        idx_r <= grant_s;
        cnt_r <= 4'(MUL_LAT - 1);
      end else if (state_r == MUL) begin
        if (cnt_zero_s) begin
          rsp_data  <= mul_p;
          rsp_valid <= onehot(idx_r);
        end else begin
          cnt_r <= cnt_r - 4'd1;
        end
      end else if (rsp_hs_s) begin
        rsp_valid <= '0;
      end else begin
        rsp_valid <= rsp_valid;
      end
    end
  end

endmodule
